// File: rtl/sparrow_pkg.sv
// Shared types for the sparrow core: branch condition encodings and the
// 2-bit saturating counter used by the bimodal branch history table.
package sparrow_pkg;

  typedef enum logic [2:0] {
    BEQ  = 3'b000,
    BNE  = 3'b001,
    BLT  = 3'b100,
    BGE  = 3'b101,
    BLTU = 3'b110,
    BGEU = 3'b111
  } b_type_e;

  typedef logic [1:0] bht_ctr_t;

  localparam bht_ctr_t BHT_SNT = 2'b00;
  localparam bht_ctr_t BHT_WNT = 2'b01;
  localparam bht_ctr_t BHT_WT  = 2'b10;
  localparam bht_ctr_t BHT_ST  = 2'b11;

  // Saturating step of one counter toward the resolved direction.
  function automatic bht_ctr_t bht_train(input bht_ctr_t ctr, input logic taken);
    bht_ctr_t next;
    next = ctr;
    if (taken && ctr != BHT_ST) begin
      next = ctr + 2'd1;
    end else if (!taken && ctr != BHT_SNT) begin
      next = ctr - 2'd1;
    end
    return next;
  endfunction

endpackage

// File: rtl/sparrow_branch_compare.sv
// Combinational branch condition evaluation over full-width operands.
// Reports whether funct3 encodes a real conditional branch.
module sparrow_branch_compare
  import sparrow_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_opr_a,
  input  logic [XLEN-1:0] i_opr_b,
  input  b_type_e         i_funct3,
  output logic            o_taken,
  output logic            o_legal
);

  logic w_eq;
  logic w_lt_s;
  logic w_lt_u;

  assign w_eq   = (i_opr_a == i_opr_b);
  assign w_lt_s = ($signed(i_opr_a) < $signed(i_opr_b));
  assign w_lt_u = (i_opr_a < i_opr_b);

  // NOTE: every output gets a default before the case so no latch is inferred
  // for the undefined encodings 010/011.
  always_comb begin
    o_taken = 1'b0;
    o_legal = 1'b1;
    case (i_funct3)
      BEQ:     o_taken = w_eq;
      BNE:     o_taken = ~w_eq;
      BLT:     o_taken = w_lt_s;
      BGE:     o_taken = ~w_lt_s;
      BLTU:    o_taken = w_lt_u;
      BGEU:    o_taken = ~w_lt_u;
      default: o_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/sparrow_branch_unit.sv
// EX-stage branch unit: resolves conditional branches, computes the redirect
// PC, owns the bimodal BHT read by fetch, and keeps saturating perf counters.
module sparrow_branch_unit
  import sparrow_pkg::*;
#(
  parameter int       XLEN        = 32,
  parameter int       BHT_ENTRIES = 64,
  parameter bht_ctr_t CTR_INIT    = BHT_WNT,
  parameter int       CNT_W       = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [XLEN-1:0]  i_fetch_pc,
  output logic             o_pred_taken,
  input  logic             i_valid,
  input  logic             i_flush,
  input  logic             i_instr_b_type,
  input  b_type_e          i_instr_funct3,
  input  logic [XLEN-1:0]  i_opr_a,
  input  logic [XLEN-1:0]  i_opr_b,
  input  logic [XLEN-1:0]  i_pc,
  input  logic [XLEN-1:0]  i_imm,
  input  logic             i_pred_taken,
  output logic             o_valid,
  output logic             o_branch_taken,
  output logic             o_mispredict,
  output logic [XLEN-1:0]  o_redirect_pc,
  output logic             o_misaligned,
  output logic [CNT_W-1:0] o_br_count,
  output logic [CNT_W-1:0] o_mp_count
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  bht_ctr_t          r_bht [BHT_ENTRIES];
  logic              r_valid;
  logic              r_taken;
  logic              r_mispredict;
  logic              r_misaligned;
  logic [XLEN-1:0]   r_redirect_pc;
  logic [CNT_W-1:0]  r_br_count;
  logic [CNT_W-1:0]  r_mp_count;

  logic [IDX_W-1:0]  w_fetch_idx;
  logic [IDX_W-1:0]  w_ex_idx;
  logic              w_cmp_taken;
  logic              w_legal;
  logic              w_resolve;
  logic              w_mispredict;
  logic [XLEN-1:0]   w_target;
  logic [XLEN-1:0]   w_seq_pc;
  logic [XLEN-1:0]   w_next_pc;
  logic              w_unused_pc_bits;

  sparrow_branch_compare #(
    .XLEN(XLEN)
  ) u_compare (
    .i_opr_a (i_opr_a),
    .i_opr_b (i_opr_b),
    .i_funct3(i_instr_funct3),
    .o_taken (w_cmp_taken),
    .o_legal (w_legal)
  );

  // Only the word-index bits of the fetch PC select a counter.
  assign w_fetch_idx      = i_fetch_pc[IDX_W+1:2];
  assign w_ex_idx         = i_pc[IDX_W+1:2];
  assign w_unused_pc_bits = ^{i_fetch_pc[XLEN-1:IDX_W+2], i_fetch_pc[1:0]};

  // Read of the stored value only: a same-cycle update is seen next cycle.
  assign o_pred_taken = r_bht[w_fetch_idx][1];

  assign w_resolve    = i_valid & i_instr_b_type & ~i_flush & w_legal;
  assign w_target     = i_pc + i_imm;
  assign w_seq_pc     = i_pc + XLEN'(4);
  assign w_next_pc    = w_cmp_taken ? w_target : w_seq_pc;
  assign w_mispredict = w_cmp_taken ^ i_pred_taken;

  // NOTE: the BHT is a plain flop array rather than a RAM, so every entry can
  // and must be forced to CTR_INIT by the asynchronous reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        r_bht[i] <= CTR_INIT;
      end
    end else if (w_resolve) begin
      r_bht[w_ex_idx] <= bht_train(r_bht[w_ex_idx], w_cmp_taken);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_valid       <= 1'b0;
      r_taken       <= 1'b0;
      r_mispredict  <= 1'b0;
      r_misaligned  <= 1'b0;
      r_redirect_pc <= '0;
    end else if (w_resolve) begin
      r_valid       <= 1'b1;
      r_taken       <= w_cmp_taken;
      r_mispredict  <= w_mispredict;
      r_misaligned  <= w_cmp_taken & (|w_target[1:0]);
      r_redirect_pc <= w_next_pc;
    end else begin
      r_valid       <= 1'b0;
      r_taken       <= 1'b0;
      r_mispredict  <= 1'b0;
      r_misaligned  <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_br_count <= '0;
      r_mp_count <= '0;
    end else if (w_resolve) begin
      if (r_br_count != '1) begin
        r_br_count <= r_br_count + CNT_W'(1);
      end
      if (w_mispredict && r_mp_count != '1) begin
        r_mp_count <= r_mp_count + CNT_W'(1);
      end
    end
  end

  assign o_valid        = r_valid;
  assign o_branch_taken = r_taken;
  assign o_mispredict   = r_mispredict;
  assign o_misaligned   = r_misaligned;
  assign o_redirect_pc  = r_redirect_pc;
  assign o_br_count     = r_br_count;
  assign o_mp_count     = r_mp_count;

endmodule
